pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core. Drives the write-enable and flush controls of the PC register, the IF/ID pipeline register (14-bit address + 32-bit instruction) and the ID/EX register.
- Resolves, in one cycle, load-use hazards, taken jumps/branches from EX, instruction-fetch wait and multi-cycle EX operations (mul/div).
- Keeps a small FSM plus diagnostic counters.

Parameters:
- REG_W, 5, register-index width.
- FLUSH_CYC, 1, bubble cycles injected into IF/ID after a taken jump; legal range 1..3.
- MC_TIMEOUT, 64, maximum cycles spent in MCWAIT before forced exit.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs1  in  REG_W  source reg 1 of the instruction in ID.
- id_rs2  in  REG_W  source reg 2 of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_W  destination reg of the EX instruction.
- ex_jump  in  1  taken jump/branch resolved in EX this cycle.
- ex_mc_start  in  1  EX holds a multi-cycle op in its first cycle.
- ex_mc_done  in  1  multi-cycle unit finishes this cycle.
- imem_ready  in  1  instruction memory output valid this cycle.
- pc_we  out  1  PC update enable.
- ifid_we  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear to NOP; dominates ifid_we.
- idex_flush  out  1  ID/EX clear to bubble.
- ex_hold  out  1  freeze EX/MEM inputs.
- state_o  out  2  FSM state: RUN=0, FLUSH=1, MCWAIT=2.
- mc_timeout_o  out  1  sticky MCWAIT-timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0.

Behaviour:
- Controls are combinational from the registered state and the current inputs, with zero-cycle latency. State and counters are registered.
- Reset, while rst=1: state=RUN, pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, ex_hold=0, flush counter=0, MCWAIT counter=0, mc_timeout_o=0, stall_cnt=0.
- Reset mid-operation (any state) aborts in that cycle. No pending flush or hold survives.
- load_use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- RUN, with priority strictly top-down:
  1. ex_jump: pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1. If FLUSH_CYC>1, go to FLUSH with fcnt=FLUSH_CYC-1; otherwise stay in RUN.
  2. ex_mc_start & !ex_mc_done: ex_hold=1, pc_we=0, ifid_we=0, idex_flush=0. Go to MCWAIT with mcnt=1.
  3. load_use: pc_we=0, ifid_we=0, idex_flush=1. Stay in RUN; exactly one bubble per hazard.
  4. !imem_ready: pc_we=0, ifid_we=1, ifid_flush=1. A NOP enters ID.
  5. Otherwise: pc_we=1, ifid_we=1, all flushes 0, ex_hold=0.
- ex_mc_start & ex_mc_done in the same cycle counts as single-cycle: no MCWAIT, and evaluation falls through to rules 3-5.
- FLUSH:
  - Outputs: ifid_we=1, ifid_flush=1, idex_flush=0, pc_we=imem_ready.
  - fcnt decrements only when imem_ready=1. When fcnt reaches 1 with imem_ready=1, go to RUN.
  - ex_jump in FLUSH: apply the rule-1 outputs and reload fcnt=FLUSH_CYC-1; go to RUN if FLUSH_CYC=1.
  - load_use is ignored in FLUSH, because ID holds a NOP.
- MCWAIT:
  - Outputs: ex_hold=1, pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=0. mcnt increments each cycle.
  - ex_mc_done: the cycle is evaluated as RUN with ex_mc_start treated as 0, ex_hold=0, then go to RUN.
  - mcnt==MC_TIMEOUT without done: set mc_timeout_o=1 (sticky until rst), ex_hold=0, go to RUN. Outputs that cycle follow RUN rules.
  - ex_jump is ignored in MCWAIT, because EX is occupied.
- stall_cnt increments on every non-reset cycle with pc_we=0 and saturates at all-ones; it does not wrap.
- Invariants:
  - ifid_flush=1 always implies ifid_we=1, except during reset.
  - ex_hold=1 only in MCWAIT or on its entry cycle.

Test Plan:
1. Reset: rst=1 for 2 cycles with any inputs -> pc_we=0, ifid_flush=1, idex_flush=1, state_o=0, stall_cnt=0. First cycle after release with imem_ready=1 -> pc_we=1, ifid_we=1.
2. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 for exactly 1 cycle. Repeat with ex_rd=0 -> no stall. Repeat with id_rs2=5, id_uses_rs2=0 -> no stall.
3. Jump priority: ex_jump=1 together with load_use=1, FLUSH_CYC=3 -> cycle 0 has pc_we=1, ifid_flush=1, idex_flush=1. Then state_o=1 for 2 cycles with ifid_flush=1, then RUN. Dropping imem_ready for 1 cycle extends FLUSH by 1.
4. Multi-cycle: ex_mc_start=1 at cycle 0, ex_mc_done=1 at cycle 4 -> ex_hold=1 and pc_we=0 for cycles 0-3, state_o=2 for cycles 1-4. At cycle 5 state_o=0, and stall_cnt increases by 4.
5. Timeout: MC_TIMEOUT=8, ex_mc_start pulse, never done -> mc_timeout_o rises on the 8th MCWAIT cycle and stays 1. Exit to RUN follows; flag clears only on rst.
6. Saturation: CNT_W=4, hold imem_ready=0 for 20 cycles -> stall_cnt stops at 15; ifid_flush=1 on every cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core pipeline registers.
// Resolves load-use, taken jumps, fetch wait and multi-cycle EX ops.
module pipe_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int FLUSH_CYC  = 1,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_jump,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    input  logic             imem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_hold,
    output logic [1:0]       state_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        MCWAIT = 2'd2
    } state_t;

    localparam int MW = $clog2(MC_TIMEOUT + 1);
    localparam logic [1:0] F_RELOAD = 2'(FLUSH_CYC - 1);

    state_t           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic             to_q, to_set;
    logic [CNT_W-1:0] cnt_q;
    logic             load_use;
    logic             run_eval, jmp_en, mc_en;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) ||
                       (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        ex_hold    = 1'b0;
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        mcnt_d     = mcnt_q;
        to_set     = 1'b0;
        run_eval   = 1'b0;
        jmp_en     = 1'b0;
        mc_en      = 1'b0;
        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (state_q)
                FLUSH: begin
                    if (ex_jump) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        fcnt_d     = F_RELOAD;
                        if (FLUSH_CYC <= 1) state_d = RUN;
                    end else begin
                        ifid_flush = 1'b1;
                        pc_we      = imem_ready;
                        if (imem_ready) begin
                            if (fcnt_q <= 2'd1) begin
                                fcnt_d  = '0;
                                state_d = RUN;
                            end else begin
                                fcnt_d = fcnt_q - 2'd1;
                            end
                        end
                    end
                end
                MCWAIT: begin
                    mcnt_d = mcnt_q + MW'(1);
                    if (ex_mc_done || (mcnt_q == MW'(MC_TIMEOUT))) begin
                        // Exit cycle is a normal RUN cycle; EX is released
                        to_set   = !ex_mc_done;
                        run_eval = 1'b1;
                        mcnt_d   = '0;
                        state_d  = RUN;
                    end else begin
                        ex_hold = 1'b1;
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                    end
                end
                default: begin
                    run_eval = 1'b1;
                    jmp_en   = 1'b1;
                    mc_en    = 1'b1;
                end
            endcase

            if (run_eval) begin
                if (jmp_en && ex_jump) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = F_RELOAD;
                    end
                end else if (mc_en && ex_mc_start && !ex_mc_done) begin
                    ex_hold = 1'b1;
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    state_d = MCWAIT;
                    mcnt_d  = MW'(1);
                end else if (load_use) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else if (!imem_ready) begin
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            mcnt_q  <= '0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            mcnt_q  <= mcnt_d;
            if (to_set) to_q <= 1'b1;
            if (!pc_we && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign state_o      = rst ? 2'd0 : state_q;
    assign mc_timeout_o = !rst && (to_q || to_set);
    assign stall_cnt    = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Vector/scoreboard bench for pipe_hazard_ctrl.
// Built with FLUSH_CYC=3, MC_TIMEOUT=8, CNT_W=4.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, ex_mem_read, ex_jump;
    logic       ex_mc_start, ex_mc_done, imem_ready;
    logic       pc_we, ifid_we, ifid_flush, idex_flush, ex_hold;
    logic [1:0] state_o;
    logic       mc_timeout_o;
    logic [3:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W(5), .FLUSH_CYC(3), .MC_TIMEOUT(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_jump(ex_jump),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .imem_ready(imem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .ex_hold(ex_hold), .state_o(state_o),
        .mc_timeout_o(mc_timeout_o), .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit rst;
        int rs1, rs2;
        bit u2, mr;
        int rd;
        bit j, ms, md, rdy;
        bit pc, iw, ifl, idf, h;
        int st;
        bit to;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[27];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(
        bit r, int rs1, int rs2, bit u2, bit mr, int rd,
        bit j, bit ms, bit md, bit rdy,
        bit pc, bit iw, bit ifl, bit idf, bit h, int st, bit to);
        vec_t v;
        v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2; v.mr = mr;
        v.rd = rd; v.j = j; v.ms = ms; v.md = md; v.rdy = rdy;
        v.pc = pc; v.iw = iw; v.ifl = ifl; v.idf = idf; v.h = h;
        v.st = st; v.to = to;
        return v;
    endfunction

    task automatic chk(input string tag, input string nm,
                       input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s %s: got %0d, expected %0d", tag, nm, act, req);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        rst         = v.rst;
        id_rs1      = 5'(v.rs1);
        id_rs2      = 5'(v.rs2);
        id_uses_rs2 = v.u2;
        ex_mem_read = v.mr;
        ex_rd       = 5'(v.rd);
        ex_jump     = v.j;
        ex_mc_start = v.ms;
        ex_mc_done  = v.md;
        imem_ready  = v.rdy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk(tag, "pc_we", int'(pc_we), int'(e.pc));
        chk(tag, "ifid_we", int'(ifid_we), int'(e.iw));
        chk(tag, "ifid_flush", int'(ifid_flush), int'(e.ifl));
        chk(tag, "idex_flush", int'(idex_flush), int'(e.idf));
        chk(tag, "ex_hold", int'(ex_hold), int'(e.h));
        chk(tag, "state_o", int'(state_o), e.st);
        chk(tag, "mc_timeout_o", int'(mc_timeout_o), int'(e.to));
        chk(tag, "stall_cnt", int'(stall_cnt), e.rst ? 0 : exp_cnt);
        @(posedge clk);
        #1;
        if (e.rst) exp_cnt = 0;
        else if (!e.pc && exp_cnt < 15) exp_cnt++;
    endtask

    initial begin
        // reset, load-use, single-cycle mc, jump/FLUSH, multi-cycle wait
        tbl[0]  = mk(1, 5,5,1,1,5, 1,1,0,0, 0,0,1,1,0, 0,0);
        tbl[1]  = mk(1, 0,0,0,0,0, 0,0,0,1, 0,0,1,1,0, 0,0);
        tbl[2]  = mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0);
        tbl[3]  = mk(0, 5,0,0,1,5, 0,0,0,1, 0,0,0,1,0, 0,0);
        tbl[4]  = mk(0, 5,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0);
        tbl[5]  = mk(0, 0,0,0,1,0, 0,0,0,1, 1,1,0,0,0, 0,0);
        tbl[6]  = mk(0, 3,5,0,1,5, 0,0,0,1, 1,1,0,0,0, 0,0);
        tbl[7]  = mk(0, 3,5,1,1,5, 0,0,0,1, 0,0,0,1,0, 0,0);
        tbl[8]  = mk(0, 0,0,0,0,0, 0,0,0,0, 0,1,1,0,0, 0,0);
        tbl[9]  = mk(0, 0,0,0,0,0, 0,1,1,1, 1,1,0,0,0, 0,0);
        tbl[10] = mk(0, 7,0,0,1,7, 0,1,1,1, 0,0,0,1,0, 0,0);
        tbl[11] = mk(0, 5,0,0,1,5, 1,0,0,1, 1,1,1,1,0, 0,0);
        tbl[12] = mk(0, 5,0,0,1,5, 0,0,0,1, 1,1,1,0,0, 1,0);
        tbl[13] = mk(0, 0,0,0,0,0, 0,0,0,0, 0,1,1,0,0, 1,0);
        tbl[14] = mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,1,0,0, 1,0);
        tbl[15] = mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0);
        tbl[16] = mk(0, 0,0,0,0,0, 1,0,0,1, 1,1,1,1,0, 0,0);
        tbl[17] = mk(0, 0,0,0,0,0, 1,0,0,1, 1,1,1,1,0, 1,0);
        tbl[18] = mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,1,0,0, 1,0);
        tbl[19] = mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,1,0,0, 1,0);
        tbl[20] = mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0);
        tbl[21] = mk(0, 0,0,0,0,0, 0,1,0,1, 0,0,0,0,1, 0,0);
        tbl[22] = mk(0, 5,0,0,1,5, 1,0,0,1, 0,0,0,0,1, 2,0);
        tbl[23] = mk(0, 0,0,0,0,0, 0,0,0,1, 0,0,0,0,1, 2,0);
        tbl[24] = mk(0, 0,0,0,0,0, 0,0,0,1, 0,0,0,0,1, 2,0);
        tbl[25] = mk(0, 0,0,0,0,0, 0,0,1,1, 1,1,0,0,0, 2,0);
        tbl[26] = mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0);

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // MCWAIT timeout after 8 cycles, sticky flag until reset
        step(mk(0, 0,0,0,0,0, 0,1,0,1, 0,0,0,0,1, 0,0), "to_entry");
        for (int i = 0; i < 7; i++)
            step(mk(0, 0,0,0,0,0, (i == 0),0,0,1, 0,0,0,0,1, 2,0),
                 $sformatf("to_wait%0d", i));
        step(mk(0, 0,0,0,0,0, 0,1,0,1, 1,1,0,0,0, 2,1), "to_exit");
        step(mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,1), "to_run");
        step(mk(0, 4,0,0,1,4, 0,0,0,1, 0,0,0,1,0, 0,1), "to_lu");
        step(mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,1), "to_keep");
        step(mk(1, 0,0,0,0,0, 0,0,0,1, 0,0,1,1,0, 0,0), "to_rst");
        step(mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0), "to_clr");

        // reset in the middle of FLUSH and MCWAIT
        step(mk(0, 0,0,0,0,0, 1,0,0,1, 1,1,1,1,0, 0,0), "mr_jmp");
        step(mk(1, 0,0,0,0,0, 0,0,0,1, 0,0,1,1,0, 0,0), "mr_rst1");
        step(mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0), "mr_run1");
        step(mk(0, 0,0,0,0,0, 0,1,0,1, 0,0,0,0,1, 0,0), "mr_mc");
        step(mk(1, 0,0,0,0,0, 0,0,0,1, 0,0,1,1,0, 0,0), "mr_rst2");
        step(mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0), "mr_run2");

        // stall counter saturation under a long fetch wait
        step(mk(1, 0,0,0,0,0, 0,0,0,0, 0,0,1,1,0, 0,0), "sat_rst");
        for (int i = 0; i < 20; i++)
            step(mk(0, 0,0,0,0,0, 0,0,0,0, 0,1,1,0,0, 0,0),
                 $sformatf("sat%0d", i));
        chk("sat", "stall_cnt", int'(stall_cnt), 15);
        step(mk(0, 0,0,0,0,0, 0,0,0,1, 1,1,0,0,0, 0,0), "sat_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
